// File: rtl/sd_ctrl_write_top.sv
// ---------------------------------------------------------------------------
// sd_ctrl_write_top
//
// FIFO-fed SD card write controller. User logic pushes 16-bit words into an
// internal synchronous FIFO. Each time a full sector is buffered, the block
// pulses wr_start_en toward the SD write engine with the next sector address.
// It walks from start_section to end_section once, then parks in DONE until
// reset. Everything runs in the sd_clk domain.
//
// Parameters
//   FIFO_DEPTH    word capacity of the FIFO (power of two, >= 2*SECTOR_WORDS,
//                 at most 1024 so the occupancy fits wr_usedw)
//   SECTOR_WORDS  16-bit words per SD sector
//
// Ports
//   sd_clk         in   clock
//   rst_n          in   synchronous active-low reset; also flushes the FIFO
//   start_section  in   first sector address, sampled on leaving IDLE
//   end_section    in   last sector address, sampled on leaving IDLE
//   wr_en/wr_din   in   user push strobe / data
//   wr_full        out  FIFO full; pushes while full are dropped
//   wr_usedw       out  FIFO occupancy 0..FIFO_DEPTH
//   sd_init_done   in   SD card initialised
//   wr_start_en    out  one-cycle sector write start pulse
//   wr_sec_addr    out  sector address, stable from the pulse to the next one
//   wr_busy        in   SD write engine busy
//   wr_req         in   SD engine asks for the next data word
//   wr_sec_data    out  word for wr_req, one registered cycle later
//   write_done     out  sticky, last sector finished
//   underflow      out  sticky, wr_req seen while the FIFO was empty
// ---------------------------------------------------------------------------
module sd_ctrl_write_top #(
    parameter int FIFO_DEPTH   = 1024,
    parameter int SECTOR_WORDS = 256
) (
    input  logic        sd_clk,
    input  logic        rst_n,
    input  logic [31:0] start_section,
    input  logic [31:0] end_section,
    input  logic        wr_en,
    input  logic [15:0] wr_din,
    output logic        wr_full,
    output logic [10:0] wr_usedw,
    input  logic        sd_init_done,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic [15:0] wr_sec_data,
    output logic        write_done,
    output logic        underflow
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [10:0] DEPTH_CNT  = 11'(FIFO_DEPTH);
    localparam logic [10:0] SECTOR_CNT = 11'(SECTOR_WORDS);

    // -----------------------------------------------------------------------
    // FIFO storage and pointers
    // -----------------------------------------------------------------------
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [10:0]   count_q, count_d;
    logic          push;
    logic          pop;

    // Read side: RAM output register only loads on a real pop, so it can map
    // onto a block RAM read port. A separate flag forces the presented word
    // to zero after reset or after an empty read.
    logic [15:0]   ram_dout_q;
    logic          data_zero_q;
    logic          underflow_q;

    assign push = wr_en && (count_q != DEPTH_CNT);
    assign pop  = wr_req && (count_q != 11'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves the count unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 11'd1;
            2'b01:   count_d = count_q - 11'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Memory array: no reset, so it infers as block RAM.
    always_ff @(posedge sd_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_din;
        end
    end

    always_ff @(posedge sd_clk) begin
        if (pop) begin
            ram_dout_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge sd_clk) begin
        if (!rst_n) begin
            data_zero_q <= 1'b1;
            underflow_q <= 1'b0;
        end else if (wr_req) begin
            data_zero_q <= !pop;
            if (!pop) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign wr_sec_data = data_zero_q ? 16'h0000 : ram_dout_q;
    assign wr_usedw    = count_q;
    assign wr_full     = (count_q == DEPTH_CNT);
    assign underflow   = underflow_q;

    // -----------------------------------------------------------------------
    // Sector sequencing state machine
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_END,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] end_q;
    logic [31:0] sec_addr_q;
    logic        start_en_q;
    logic        done_q;

    always_ff @(posedge sd_clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            end_q      <= '0;
            sec_addr_q <= '0;
            start_en_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sd_init_done) begin
                        addr_q  <= start_section;
                        end_q   <= end_section;
                        state_q <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    // Pulse and address are registered together so the
                    // engine sees a stable address in the pulse cycle.
                    if ((count_q >= SECTOR_CNT) && !done_q) begin
                        start_en_q <= 1'b1;
                        sec_addr_q <= addr_q;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (wr_busy) begin
                        state_q <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    if (!wr_busy) begin
                        // ">=" also covers end < start: one sector, then stop.
                        if (addr_q >= end_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            addr_q  <= addr_q + 32'd1;
                            state_q <= S_WAIT_DATA;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_start_en = start_en_q;
    assign wr_sec_addr = sec_addr_q;
    assign write_done  = done_q;

endmodule
